// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: register map, geometry and helpers shared by the timer scheduler.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package timer_sched_pkg;

  localparam int MAX_CH    = 16;
  localparam int CH_STRIDE = 8;

  // Per-channel offsets within a CH_STRIDE window, and global registers.
  localparam logic [7:0] OFF_ACC      = 8'h00;
  localparam logic [7:0] OFF_INC      = 8'h04;
  localparam logic [7:0] OFF_PENDING  = 8'h80;
  localparam logic [7:0] OFF_IRQ_MASK = 8'h84;
  localparam logic [7:0] OFF_CTRL     = 8'h88;

  localparam int CTRL_EN = 0;

  // Width of the round-robin slot index; at least one bit even for a single channel.
  function automatic int slot_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Replace only the strobed bytes of old_v with the matching bytes of wdata.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_sched_regfile.sv
// timer_sched_regfile: per-channel ACC/INC storage with a scheduler RMW port and a bus byte-write port.
// Latency: writes land on the next clk; contents are visible combinationally on acc/inc.
// Backpressure: none; a bus write to the ACC being serviced wins and the scheduler update is dropped.
// Ports: clk/resetn; upd_en/upd_ch/upd_acc (scheduler write-back); bus_we/bus_inc/bus_ch/bus_strb/
//   bus_wdata (bus byte write, bus_inc selects INC over ACC); acc/inc (all channels); upd_drop.
module timer_sched_regfile
  import timer_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SW     = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    upd_en,
  input  logic [SW-1:0]           upd_ch,
  input  logic [31:0]             upd_acc,
  input  logic                    bus_we,
  input  logic                    bus_inc,
  input  logic [SW-1:0]           bus_ch,
  input  logic [3:0]              bus_strb,
  input  logic [31:0]             bus_wdata,
  output logic [NUM_CH-1:0][31:0] acc,
  output logic [NUM_CH-1:0][31:0] inc,
  output logic                    upd_drop
);

  // The scheduler loses its whole update (carry included) when the bus writes the same ACC.
  assign upd_drop = upd_en && bus_we && !bus_inc && (bus_ch == upd_ch);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc <= '0;
      inc <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus_we && !bus_inc && (int'(bus_ch) == c)) begin
          acc[c] <= byte_merge(acc[c], bus_wdata, bus_strb);
        end else if (upd_en && (int'(upd_ch) == c)) begin
          acc[c] <= upd_acc;
        end
        // INC written on the service edge is seen by the next service only.
        if (bus_we && bus_inc && (int'(bus_ch) == c)) begin
          inc[c] <= byte_merge(inc[c], bus_wdata, bus_strb);
        end
      end
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// timer_scheduler: NUM_CH phase accumulators sharing one 33-bit adder, one channel serviced per clk.
// Latency: bus ack one clk after valid; overflow/pending/irq registered one clk after the service edge.
// Backpressure: single-cycle ready pulse; a new request is accepted only after ready has dropped.
// Ports: clk, resetn (sync, active-low); iomem_valid/ready/wstrb/addr/wdata/rdata (picosoc iomem slave);
//   overflow (per-channel wrap pulse); irq (level). Build option: TIMER_SCHED_IRQ_EN adds IRQ_MASK and irq.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  output logic [NUM_CH-1:0] overflow,
  output logic              irq
);

  localparam int              SW        = slot_width(NUM_CH);
  localparam logic [SW-1:0]   LAST_SLOT = SW'(NUM_CH - 1);

  logic [NUM_CH-1:0][31:0] acc, inc;
  logic [SW-1:0]           slot;
  logic                    en;
  logic [NUM_CH-1:0]       pending, pend_nxt, set_vec, clr_vec;
  logic                    accept, wr, in_ch, upd_drop;
  logic [7:0]              waddr;
  logic [SW-1:0]           bch;
  logic [31:0]             bmask, rd_val, mask_rd;
  logic [32:0]             sum;
  logic                    unused_addr;

  assign accept      = iomem_valid && !iomem_ready;
  assign wr          = accept && (iomem_wstrb != 4'b0000);
  assign waddr       = {iomem_addr[7:2], 2'b00};
  assign in_ch       = !waddr[7] && (int'(waddr[6:3]) < NUM_CH);
  assign bch         = SW'(waddr[6:3]);
  assign bmask       = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign unused_addr = ^{iomem_addr[31:8], iomem_addr[1:0]};

  timer_sched_regfile #(.NUM_CH(NUM_CH), .SW(SW)) u_regfile (
    .clk       (clk),
    .resetn    (resetn),
    .upd_en    (en),
    .upd_ch    (slot),
    .upd_acc   (sum[31:0]),
    .bus_we    (wr && in_ch),
    .bus_inc   (waddr[2]),
    .bus_ch    (bch),
    .bus_strb  (iomem_wstrb),
    .bus_wdata (iomem_wdata),
    .acc       (acc),
    .inc       (inc),
    .upd_drop  (upd_drop)
  );

  assign sum      = {1'b0, acc[slot]} + {1'b0, inc[slot]};
  assign set_vec  = (en && sum[32] && !upd_drop) ? (NUM_CH'(1) << slot) : '0;
  assign clr_vec  = (wr && (waddr == OFF_PENDING)) ? NUM_CH'(iomem_wdata & bmask) : '0;
  // Clear first, then set: a wrap on the same edge as its W1C keeps the bit.
  assign pend_nxt = (pending & ~clr_vec) | set_vec;

`ifdef TIMER_SCHED_IRQ_EN
  logic [NUM_CH-1:0] mask, mask_nxt;
  logic [31:0]       mask_wr;

  assign mask_wr  = byte_merge(32'(mask), iomem_wdata, iomem_wstrb);
  assign mask_nxt = (wr && (waddr == OFF_IRQ_MASK)) ? NUM_CH'(mask_wr) : mask;
  assign mask_rd  = 32'(mask);

  // Built from next-state values so irq tracks pending/mask with no extra lag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      mask <= mask_nxt;
      irq  <= |(pend_nxt & mask_nxt);
    end
  end
`else
  assign mask_rd = '0;
  assign irq     = 1'b0;
`endif

  // Reads see register values from before this edge's scheduler update.
  always_comb begin
    rd_val = '0;
    if (in_ch)                          rd_val = waddr[2] ? inc[bch] : acc[bch];
    else if (waddr == OFF_PENDING)      rd_val = 32'(pending);
    else if (waddr == OFF_IRQ_MASK)     rd_val = mask_rd;
    else if (waddr == OFF_CTRL)         rd_val = 32'(en) << CTRL_EN;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      slot        <= '0;
      en          <= 1'b0;
      pending     <= '0;
      overflow    <= '0;
    end else begin
      iomem_ready <= accept;
      if (accept) iomem_rdata <= rd_val;
      overflow <= set_vec;
      pending  <= pend_nxt;
      if (en) slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
      if (wr && (waddr == OFF_CTRL) && iomem_wstrb[0]) en <= iomem_wdata[CTRL_EN];
    end
  end

endmodule
